// File: rtl/sprite_row_fetcher_if.sv
// Sprite row fetcher bus: request side (start/abort/geometry), memory handshake and status.
// master: the requester/memory side that drives requests and mem_ready.
// slave : the fetcher itself, which produces addresses and status pulses.
interface sprite_row_fetcher_if #(
  parameter int unsigned SIZE_X       = 10,
  parameter int unsigned SIZE_Y       = 9,
  parameter int unsigned SIZE_ADDRESS = 17
);
  logic                    start;
  logic                    abort;
  logic                    mirror_x;
  logic [SIZE_ADDRESS-1:0] base_address;
  logic [SIZE_X-1:0]       sprite_x;
  logic [SIZE_Y-1:0]       sprite_y;
  logic [SIZE_Y-1:0]       pixel_y;
  logic                    mem_ready;
  logic [SIZE_ADDRESS-1:0] memory_address;
  logic                    addr_valid;
  logic [SIZE_X-1:0]       screen_x;
  logic                    busy;
  logic                    count_finished;
  logic                    miss;

  modport master (
    output start, abort, mirror_x, base_address, sprite_x, sprite_y, pixel_y, mem_ready,
    input  memory_address, addr_valid, screen_x, busy, count_finished, miss
  );

  modport slave (
    input  start, abort, mirror_x, base_address, sprite_x, sprite_y, pixel_y, mem_ready,
    output memory_address, addr_valid, screen_x, busy, count_finished, miss
  );
endinterface

// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: on start, checks whether the current scan line hits the sprite and, if so,
// walks one sprite row presenting memory addresses (optionally mirrored) with their screen column.
// Ports:
//   clk_pixel - pixel clock, all state on rising edge
//   reset     - asynchronous active-low reset
//   bus       - request inputs, memory handshake (mem_ready) and registered address/status outputs
module sprite_row_fetcher #(
  parameter int unsigned SIZE_X       = 10,
  parameter int unsigned SIZE_Y       = 9,
  parameter int unsigned SIZE_ADDRESS = 17,
  parameter int unsigned SPRITE_W     = 20,
  parameter int unsigned SPRITE_H     = 20
) (
  input logic                 clk_pixel,
  input logic                 reset,
  sprite_row_fetcher_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam int unsigned YExtW = SIZE_Y + 1;

  localparam logic [SIZE_X-1:0]       ColLast   = SIZE_X'(SPRITE_W - 1);
  localparam logic [SIZE_ADDRESS-1:0] RowStride = SIZE_ADDRESS'(SPRITE_W);
  localparam logic [SIZE_ADDRESS-1:0] MirrorOfs = SIZE_ADDRESS'(SPRITE_W - 1);
  localparam logic [SIZE_Y:0]         HeightExt = YExtW'(SPRITE_H);

  logic [1:0]              state_q, state_d;
  logic [SIZE_X-1:0]       col_q, col_d;
  logic                    mirror_q, mirror_d;
  logic [SIZE_ADDRESS-1:0] addr_q, addr_d;
  logic [SIZE_X-1:0]       sx_q, sx_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    fin_q, fin_d;
  logic                    miss_q, miss_d;

  // Range check in SIZE_Y+1 bits so sprite_y + SPRITE_H cannot wrap past the top of the screen.
  logic [SIZE_Y:0]         py_ext, sy_ext, sy_end;
  logic                    in_range;
  logic [SIZE_Y-1:0]       row;
  logic [SIZE_ADDRESS-1:0] row_base;

  assign py_ext   = {1'b0, bus.pixel_y};
  assign sy_ext   = {1'b0, bus.sprite_y};
  assign sy_end   = sy_ext + HeightExt;
  assign in_range = (py_ext >= sy_ext) && (py_ext < sy_end);
  assign row      = bus.pixel_y - bus.sprite_y;
  assign row_base = bus.base_address + SIZE_ADDRESS'(row) * RowStride;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    mirror_d = mirror_q;
    addr_d   = addr_q;
    sx_d     = sx_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    fin_d    = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (in_range) begin
            state_d  = StFetch;
            col_d    = '0;
            mirror_d = bus.mirror_x;
            addr_d   = bus.mirror_x ? row_base + MirrorOfs : row_base;
            sx_d     = bus.sprite_x;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = StDone;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            miss_d  = 1'b1;
          end
        end
      end
      StFetch: begin
        if (bus.abort) begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (bus.mem_ready) begin
          if (col_q == ColLast) begin
            state_d = StDone;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
          end else begin
            // Stepping by +/-1 equals row_base + col (or its mirror) modulo 2^SIZE_ADDRESS.
            col_d  = col_q + 1'b1;
            addr_d = mirror_q ? addr_q - 1'b1 : addr_q + 1'b1;
            sx_d   = sx_q + 1'b1;
          end
        end
      end
      StDone: begin
        // The pulse is only one cycle wide; abort here lands in the same place.
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      col_q    <= '0;
      mirror_q <= 1'b0;
      addr_q   <= '0;
      sx_q     <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      mirror_q <= mirror_d;
      addr_q   <= addr_d;
      sx_q     <= sx_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      fin_q    <= fin_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.memory_address = addr_q;
  assign bus.addr_valid     = valid_q;
  assign bus.screen_x       = sx_q;
  assign bus.busy           = busy_q;
  assign bus.count_finished = fin_q;
  assign bus.miss           = miss_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
module tb_sprite_row_fetcher;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sprite_row_fetcher_if #(.SIZE_X(10), .SIZE_Y(9), .SIZE_ADDRESS(17)) bus ();

  sprite_row_fetcher #(
    .SIZE_X      (10),
    .SIZE_Y      (9),
    .SIZE_ADDRESS(17),
    .SPRITE_W    (20),
    .SPRITE_H    (20)
  ) dut (
    .clk_pixel(clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [16:0] base;
    logic [8:0]  sy;
    logic [8:0]  py;
    logic [9:0]  sx;
    logic        mirror;
    logic        exp_miss;
    logic [16:0] exp_first;  // expected address at col 0
  } vec_t;

  localparam int NVec = 9;
  vec_t vecs[NVec];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input vec_t v);
    bus.base_address = v.base;
    bus.sprite_y     = v.sy;
    bus.pixel_y      = v.py;
    bus.sprite_x     = v.sx;
    bus.mirror_x     = v.mirror;
    bus.start        = 1'b1;
  endtask

  function automatic logic [16:0] exp_addr(input vec_t v, input int k);
    return v.mirror ? v.exp_first - 17'(k) : v.exp_first + 17'(k);
  endfunction

  // Full row with mem_ready high, starting from IDLE in the current cycle.
  task automatic run_row(input vec_t v);
    set_req(v);
    step();
    bus.start = 1'b0;
    if (v.exp_miss) begin
      chk("miss_valid", 32'(bus.addr_valid), 0);
      chk("miss_fin", 32'(bus.count_finished), 1);
      chk("miss_pulse", 32'(bus.miss), 1);
      chk("miss_busy", 32'(bus.busy), 0);
      step();
      chk("miss_fin_end", 32'(bus.count_finished), 0);
      chk("miss_pulse_end", 32'(bus.miss), 0);
    end else begin
      for (int k = 0; k < 20; k++) begin
        chk("row_valid", 32'(bus.addr_valid), 1);
        chk("row_busy", 32'(bus.busy), 1);
        chk("row_addr", 32'(bus.memory_address), 32'(exp_addr(v, k)));
        chk("row_sx", 32'(bus.screen_x), 32'(v.sx + 10'(k)));
        chk("row_fin_early", 32'(bus.count_finished), 0);
        step();
      end
      chk("done_valid", 32'(bus.addr_valid), 0);
      chk("done_busy", 32'(bus.busy), 0);
      chk("done_fin", 32'(bus.count_finished), 1);
      chk("done_miss", 32'(bus.miss), 0);
      step();
      chk("idle_fin", 32'(bus.count_finished), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{base: 17'd100,    sy: 9'd50,  py: 9'd53,  sx: 10'd30,   mirror: 1'b0,
                exp_miss: 1'b0, exp_first: 17'd160};
    vecs[1] = '{base: 17'd100,    sy: 9'd50,  py: 9'd53,  sx: 10'd30,   mirror: 1'b1,
                exp_miss: 1'b0, exp_first: 17'd179};
    vecs[2] = '{base: 17'd0,      sy: 9'd50,  py: 9'd50,  sx: 10'd0,    mirror: 1'b0,
                exp_miss: 1'b0, exp_first: 17'd0};
    vecs[3] = '{base: 17'd1000,   sy: 9'd50,  py: 9'd69,  sx: 10'd1000, mirror: 1'b0,
                exp_miss: 1'b0, exp_first: 17'd1380};
    vecs[4] = '{base: 17'd100,    sy: 9'd50,  py: 9'd70,  sx: 10'd30,   mirror: 1'b0,
                exp_miss: 1'b1, exp_first: 17'd0};
    vecs[5] = '{base: 17'd100,    sy: 9'd50,  py: 9'd49,  sx: 10'd30,   mirror: 1'b0,
                exp_miss: 1'b1, exp_first: 17'd0};
    vecs[6] = '{base: 17'd0,      sy: 9'd500, py: 9'd511, sx: 10'd7,    mirror: 1'b1,
                exp_miss: 1'b0, exp_first: 17'd239};
    vecs[7] = '{base: 17'd0,      sy: 9'd500, py: 9'd5,   sx: 10'd7,    mirror: 1'b0,
                exp_miss: 1'b1, exp_first: 17'd0};
    vecs[8] = '{base: 17'd131067, sy: 9'd50,  py: 9'd50,  sx: 10'd0,    mirror: 1'b0,
                exp_miss: 1'b0, exp_first: 17'd131067};

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.mirror_x     = 1'b0;
    bus.base_address = '0;
    bus.sprite_x     = '0;
    bus.sprite_y     = '0;
    bus.pixel_y      = '0;
    bus.mem_ready    = 1'b1;
    step();
    step();
    chk("rst_addr", 32'(bus.memory_address), 0);
    chk("rst_sx", 32'(bus.screen_x), 0);
    chk("rst_valid", 32'(bus.addr_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_fin", 32'(bus.count_finished), 0);
    chk("rst_miss", 32'(bus.miss), 0);
    rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) run_row(vecs[i]);

    // Stall: mem_ready low for 3 cycles while col 5 is presented.
    begin
      int cyc = 0;
      set_req(vecs[0]);
      step();
      bus.start = 1'b0;
      for (int k = 0; k < 20; k++) begin
        chk("stall_addr", 32'(bus.memory_address), 32'(160 + k));
        chk("stall_valid", 32'(bus.addr_valid), 1);
        if (k == 5) begin
          bus.mem_ready = 1'b0;
          repeat (3) begin
            step();
            cyc++;
            chk("stall_hold_addr", 32'(bus.memory_address), 165);
            chk("stall_hold_sx", 32'(bus.screen_x), 35);
            chk("stall_hold_valid", 32'(bus.addr_valid), 1);
          end
          bus.mem_ready = 1'b1;
        end
        step();
        cyc++;
      end
      chk("stall_fin", 32'(bus.count_finished), 1);
      chk("stall_len", 32'(cyc), 23);
      step();
    end

    // Abort at col 10; start with other inputs during FETCH must be ignored.
    set_req(vecs[0]);
    step();
    bus.base_address = 17'd0;
    bus.mirror_x     = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      chk("abort_addr", 32'(bus.memory_address), 32'(160 + k));
      if (k < 10) step();
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_valid", 32'(bus.addr_valid), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_fin", 32'(bus.count_finished), 0);
    chk("abort_miss", 32'(bus.miss), 0);
    repeat (3) begin
      step();
      chk("abort_no_fin", 32'(bus.count_finished), 0);
      chk("abort_idle_valid", 32'(bus.addr_valid), 0);
    end

    // Asynchronous reset at col 7, then a fresh row from col 0.
    set_req(vecs[0]);
    step();
    bus.start = 1'b0;
    repeat (7) step();
    chk("pre_rst_addr", 32'(bus.memory_address), 167);
    rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.memory_address), 0);
    chk("arst_sx", 32'(bus.screen_x), 0);
    chk("arst_valid", 32'(bus.addr_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_fin", 32'(bus.count_finished), 0);
    step();
    chk("arst_hold_valid", 32'(bus.addr_valid), 0);
    rst_n = 1'b1;
    run_row(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_row_fetcher.md
SPRITE_ROW_FETCHER -- requirements
Module: sprite_row_fetcher

Interface
REQ-001 SHALL have parameter SIZE_X, default 10, width of screen x coordinates.
REQ-002 SHALL have parameter SIZE_Y, default 9, width of screen y coordinates.
REQ-003 SHALL have parameter SIZE_ADDRESS, default 17, sprite memory address width.
REQ-004 SHALL have parameter SPRITE_W, default 20, pixels per sprite row, range 1..2^SIZE_X-1.
REQ-005 SHALL have parameter SPRITE_H, default 20, rows per sprite, range 1..2^SIZE_Y-1.
REQ-006 clk_pixel  input  1  pixel clock; the only clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request to fetch one sprite row; sampled only in IDLE.
REQ-009 abort  input  1  cancel the current fetch.
REQ-010 mirror_x  input  1  1 = emit the row right-to-left (horizontal flip).
REQ-011 base_address  input  SIZE_ADDRESS  sprite offset in memory.
REQ-012 sprite_x  input  SIZE_X  screen column of sprite pixel 0.
REQ-013 sprite_y  input  SIZE_Y  screen row of sprite row 0.
REQ-014 pixel_y  input  SIZE_Y  current scan line.
REQ-015 mem_ready  input  1  memory accepts the presented address this cycle.
REQ-016 memory_address  output  SIZE_ADDRESS  address being presented.
REQ-017 addr_valid  output  1  memory_address and screen_x are valid.
REQ-018 screen_x  output  SIZE_X  screen column associated with memory_address.
REQ-019 busy  output  1  fetch in progress.
REQ-020 count_finished  output  1  one-cycle pulse at end of a row, or on a miss.
REQ-021 miss  output  1  one-cycle pulse, coincident with count_finished, when pixel_y is outside the sprite.

Function
REQ-022 SHALL implement FSM states IDLE, FETCH, DONE; all outputs registered.
REQ-023 IDLE, start=1, sprite_y<=pixel_y<sprite_y+SPRITE_H: latch inputs.
- row = pixel_y-sprite_y; row_base = base_address + row*SPRITE_W; col=0.
- Enter FETCH; addr_valid=1 and busy=1 after that same edge.
REQ-024 IDLE, start=1, row out of range: enter DONE; count_finished=1 and miss=1 for one cycle; no addr_valid.
REQ-025 In FETCH:
- memory_address = row_base + col, or row_base + (SPRITE_W-1-col) when latched mirror_x=1.
- screen_x = latched sprite_x + col.
REQ-026 In FETCH, an edge with mem_ready=1 accepts the address and increments col; mem_ready=0 holds all outputs stable.
REQ-027 Accept at col=SPRITE_W-1: enter DONE; addr_valid=0, busy=0, count_finished=1 for one cycle; return to IDLE on the next edge.
REQ-028 Minimum row duration with mem_ready tied high: SPRITE_W cycles of addr_valid, then 1 DONE cycle; a new start is accepted in the cycle after DONE.
REQ-029 start while in FETCH or DONE is ignored; inputs other than mem_ready and abort are ignored outside IDLE.
REQ-030 abort=1 in FETCH or DONE: go to IDLE next edge; addr_valid, busy, count_finished, miss all 0; abort has priority over mem_ready.
REQ-031 Address arithmetic is modulo 2^SIZE_ADDRESS (wraps silently); screen_x is modulo 2^SIZE_X.
REQ-032 The range comparison uses SIZE_Y+1 bits so that sprite_y+SPRITE_H never wraps.

Reset
REQ-033 reset=0 asynchronously forces IDLE, col=0, memory_address=0, screen_x=0, and addr_valid=busy=count_finished=miss=0, including mid-fetch.
REQ-034 After reset release, the first start is accepted on the first rising edge with reset=1.

Verification
REQ-035 Normal row: defaults, base=100, sprite_y=50, pixel_y=53, sprite_x=30, mem_ready=1 -> addresses 160..179, screen_x 30..49 over 20 cycles, then a single count_finished pulse.
REQ-036 Mirror: same stimulus with mirror_x=1 -> addresses 179 down to 160, screen_x 30..49.
REQ-037 Stall: mem_ready=0 for 3 cycles at col=5 -> address 165 held for 4 cycles, 20 distinct addresses in total, row ends 3 cycles later.
REQ-038 Miss: pixel_y=70, sprite_y=50 -> no addr_valid; count_finished=1 and miss=1 for one cycle, then IDLE.
REQ-039 Wrap: base=2^17-5 -> addresses wrap to 0 after 131071, with no stall.
REQ-040 Abort and reset: abort at col=10 -> IDLE next edge, no count_finished; reset=0 at col=7 -> all outputs 0 immediately; a fresh start afterwards fetches from col=0.
